// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, early branch
// resolution and hazard detection for the five-stage pipeline.
module id_stage #(
  parameter int LEN_WORD = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LEN_WORD-1:0] if_inced_pc,
  input  logic [LEN_WORD-1:0] if_instruction,
  input  logic                wb_reg_write,
  input  logic [4:0]          wb_write_reg,
  input  logic [LEN_WORD-1:0] wb_write_data,
  input  logic                ex_mem_read,
  input  logic                ex_reg_write,
  input  logic [4:0]          ex_write_reg,
  input  logic                mem_mem_read,
  input  logic                mem_reg_write,
  input  logic [4:0]          mem_write_reg,
  input  logic [LEN_WORD-1:0] mem_alu_result,
  output logic                stall,
  output logic                pc_src,
  output logic [LEN_WORD-1:0] jump_pc,
  output logic                id_valid,
  output logic [LEN_WORD-1:0] id_inced_pc,
  output logic [LEN_WORD-1:0] id_instruction,
  output logic [LEN_WORD-1:0] read_data_1,
  output logic [LEN_WORD-1:0] read_data_2,
  output logic [LEN_WORD-1:0] imm_ext,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd
);

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  logic [LEN_WORD-1:0] pc_q;
  logic [LEN_WORD-1:0] instr_q;
  logic                valid_q;
  logic [LEN_WORD-1:0] regs [NUM_REGS];

  logic                wb_en;
  logic [LEN_WORD-1:0] cmp_a;
  logic [LEN_WORD-1:0] cmp_b;
  logic [5:0]          opcode;
  logic                is_j;
  logic                is_br;
  logic                taken;
  logic                load_use;
  logic                branch_hazard;
  logic                ex_rs, ex_rt;
  logic                mem_rs, mem_rt;
  logic                mem_fwd;
  logic [LEN_WORD-1:0] target;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (stall) begin
      pc_q    <= pc_q;
      instr_q <= instr_q;
      valid_q <= valid_q;
    end else if (pc_src) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= if_inced_pc;
      instr_q <= if_instruction;
      valid_q <= 1'b1;
    end
  end

  assign wb_en = wb_reg_write && (wb_write_reg != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_write_reg] <= wb_write_data;
    end
  end

  assign opcode  = instr_q[31:26];
  assign rs      = instr_q[25:21];
  assign rt      = instr_q[20:16];
  assign rd      = instr_q[15:11];
  assign imm_ext = {{(LEN_WORD-16){instr_q[15]}}, instr_q[15:0]};

  // Register 0 wins over the WB bypass so it always reads zero.
  always_comb begin
    read_data_1 = regs[rs];
    read_data_2 = regs[rt];
    if (wb_en && wb_write_reg == rs) read_data_1 = wb_write_data;
    if (wb_en && wb_write_reg == rt) read_data_2 = wb_write_data;
    if (rs == 5'd0) read_data_1 = '0;
    if (rt == 5'd0) read_data_2 = '0;
  end

  assign mem_fwd = mem_reg_write && !mem_mem_read
                && (mem_write_reg != 5'd0);

  always_comb begin
    cmp_a = read_data_1;
    cmp_b = read_data_2;
    if (mem_fwd && mem_write_reg == rs) cmp_a = mem_alu_result;
    if (mem_fwd && mem_write_reg == rt) cmp_b = mem_alu_result;
  end

  assign is_j  = (opcode == OP_J);
  assign is_br = (opcode == OP_BEQ) || (opcode == OP_BNE);

  always_comb begin
    taken  = 1'b0;
    target = pc_q + {imm_ext[LEN_WORD-3:0], 2'b00};
    unique case (1'b1)
      opcode == OP_BEQ: taken = (cmp_a == cmp_b);
      opcode == OP_BNE: taken = (cmp_a != cmp_b);
      opcode == OP_J: begin
        taken  = 1'b1;
        target = {pc_q[31:28], instr_q[25:0], 2'b00};
      end
      default: taken = 1'b0;
    endcase
  end

  assign ex_rs  = (ex_write_reg != 5'd0) && (ex_write_reg == rs);
  assign ex_rt  = (ex_write_reg != 5'd0) && (ex_write_reg == rt);
  assign mem_rs = (mem_write_reg != 5'd0) && (mem_write_reg == rs);
  assign mem_rt = (mem_write_reg != 5'd0) && (mem_write_reg == rt);

  assign load_use      = ex_mem_read && (ex_rs || ex_rt) && !is_j;
  assign branch_hazard = is_br
                      && ((ex_reg_write && (ex_rs || ex_rt))
                       || (mem_mem_read && (mem_rs || mem_rt)));

  assign stall    = valid_q && (load_use || branch_hazard);
  assign pc_src   = valid_q && taken && !stall;
  assign id_valid = valid_q && !stall;
  assign jump_pc  = (valid_q && taken) ? target : '0;

  assign id_inced_pc    = pc_q;
  assign id_instruction = instr_q;

endmodule
